// File: rtl/truth_table_scanner.sv
// truth_table_scanner: steps a 4-input function block through vectors 0..15,
// samples F after a settle window per vector, and compares the observed truth
// table against EXPECTED. Results (pass, mismatch count, lowest failing
// minterm) are held until the next start or reset.
//
// Handshake: start is a level sampled only in IDLE or DONE; one cycle high is
// enough. busy is high for the whole scan, and start is ignored while it is
// high. done stays high until the next accepted start or rst.
module truth_table_scanner #(
    parameter int          SETTLE   = 1,
    parameter logic [15:0] EXPECTED = 16'hDF03
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        A,
    output logic        B,
    output logic        C,
    output logic        D,
    input  logic        F,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] captured,
    output logic [4:0]  mismatch_cnt,
    output logic [3:0]  first_fail,
    output logic        fail_valid
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [3:0] SETTLE_C = 4'(SETTLE);

    state_t      state_q, state_d;
    logic [3:0]  vec_q, vec_d;
    logic [3:0]  wait_cnt_q, wait_cnt_d;
    logic [15:0] captured_q, captured_d;
    logic [4:0]  mismatch_cnt_q, mismatch_cnt_d;
    logic [3:0]  first_fail_q, first_fail_d;
    logic        fail_valid_q, fail_valid_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        pass_q, pass_d;

    // Next-state and result bookkeeping for the scan FSM.
    always_comb begin
        state_d        = state_q;
        vec_d          = vec_q;
        wait_cnt_d     = wait_cnt_q;
        captured_d     = captured_q;
        mismatch_cnt_d = mismatch_cnt_q;
        first_fail_d   = first_fail_q;
        fail_valid_d   = fail_valid_q;
        busy_d         = busy_q;
        done_d         = done_q;
        pass_d         = pass_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d        = S_RUN;
                    vec_d          = 4'd0;
                    wait_cnt_d     = 4'd0;
                    captured_d     = 16'h0000;
                    mismatch_cnt_d = 5'd0;
                    first_fail_d   = 4'd0;
                    fail_valid_d   = 1'b0;
                    busy_d         = 1'b1;
                    done_d         = 1'b0;
                    pass_d         = 1'b0;
                end
            end
            S_RUN: begin
                if (wait_cnt_q == SETTLE_C) begin
                    wait_cnt_d        = 4'd0;
                    captured_d[vec_q] = F;
                    if (F != EXPECTED[vec_q]) begin
                        mismatch_cnt_d = mismatch_cnt_q + 5'd1;
                        if (!fail_valid_q) begin
                            first_fail_d = vec_q;
                            fail_valid_d = 1'b1;
                        end
                    end
                    if (vec_q == 4'd15) begin
                        // Last sample is folded into pass on this same edge.
                        state_d = S_DONE;
                        vec_d   = 4'd0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        pass_d  = (mismatch_cnt_d == 5'd0);
                    end else begin
                        vec_d = vec_q + 4'd1;
                    end
                end else begin
                    wait_cnt_d = wait_cnt_q + 4'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and result registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            vec_q          <= 4'd0;
            wait_cnt_q     <= 4'd0;
            captured_q     <= 16'h0000;
            mismatch_cnt_q <= 5'd0;
            first_fail_q   <= 4'd0;
            fail_valid_q   <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            pass_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            vec_q          <= vec_d;
            wait_cnt_q     <= wait_cnt_d;
            captured_q     <= captured_d;
            mismatch_cnt_q <= mismatch_cnt_d;
            first_fail_q   <= first_fail_d;
            fail_valid_q   <= fail_valid_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            pass_q         <= pass_d;
        end
    end

    assign {A, B, C, D}  = vec_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign pass          = pass_q;
    assign captured      = captured_q;
    assign mismatch_cnt  = mismatch_cnt_q;
    assign first_fail    = first_fail_q;
    assign fail_valid    = fail_valid_q;

endmodule

// File: tb/tb_truth_table_scanner.sv
// Bench for truth_table_scanner: a modelled function block with selectable
// faults drives F; scan results are checked against a table of expected
// records queued at start time and popped when done rises.
module tb_truth_table_scanner;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // ---------------- DUT 0: SETTLE=1 ----------------
    logic        start;
    logic        a, b, c, d, f;
    logic        busy, done, pass, fail_valid;
    logic [15:0] captured;
    logic [4:0]  mismatch_cnt;
    logic [3:0]  first_fail;
    int          fault_mode;

    truth_table_scanner #(.SETTLE(1), .EXPECTED(16'hDF03)) u_dut (
        .clk(clk), .rst(rst), .start(start),
        .A(a), .B(b), .C(c), .D(d), .F(f),
        .busy(busy), .done(done), .pass(pass),
        .captured(captured), .mismatch_cnt(mismatch_cnt),
        .first_fail(first_fail), .fail_valid(fail_valid)
    );

    // ---------------- DUT 1: SETTLE=0 ----------------
    logic        start0;
    logic        a0, b0, c0, d0, f0;
    logic        busy0, done0, pass0, fail_valid0;
    logic [15:0] captured0;
    logic [4:0]  mismatch_cnt0;
    logic [3:0]  first_fail0;

    truth_table_scanner #(.SETTLE(0), .EXPECTED(16'hDF03)) u_dut0 (
        .clk(clk), .rst(rst), .start(start0),
        .A(a0), .B(b0), .C(c0), .D(d0), .F(f0),
        .busy(busy0), .done(done0), .pass(pass0),
        .captured(captured0), .mismatch_cnt(mismatch_cnt0),
        .first_fail(first_fail0), .fail_valid(fail_valid0)
    );

    // Golden F = m(0,1,8,9,10,11,12,14,15) as a sum of products.
    function automatic logic golden(input logic ia, ib, ic, id);
        return (~ia & ~ib & ~ic) | (ia & ~ib) | (ia & ib & (ic | ~id));
    endfunction

    // Modelled function block: 0 golden, 1 stuck-0, 2 stuck-1, 3 F=1 at vector 13.
    always_comb begin
        f = golden(a, b, c, d);
        case (fault_mode)
            1: f = 1'b0;
            2: f = 1'b1;
            3: if ({a, b, c, d} == 4'd13) f = 1'b1;
            default: ;
        endcase
    end
    assign f0 = golden(a0, b0, c0, d0);

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic [15:0] cap;
        logic [4:0]  mm;
        logic [3:0]  ff;
        logic        fv;
        logic        ps;
    } res_t;

    logic [26:0] exp_q[$];
    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_results(input string tag);
        res_t e;
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s: expectation queue empty", tag);
        end else begin
            e = res_t'(exp_q.pop_front());
            check({tag, " captured"},     32'(captured),     32'(e.cap));
            check({tag, " mismatch_cnt"}, 32'(mismatch_cnt), 32'(e.mm));
            check({tag, " fail_valid"},   32'(fail_valid),   32'(e.fv));
            if (e.fv) check({tag, " first_fail"}, 32'(first_fail), 32'(e.ff));
            check({tag, " pass"},         32'(pass),         32'(e.ps));
            check({tag, " busy_low"},     32'(busy),         32'd0);
        end
    endtask

    // ---------------- driver ----------------
    // Pulses start, verifies results cleared after E0, optionally checks the
    // vector sequence, optionally pulses start again at cycle pulse_at, then
    // waits for done and checks the scan length and queued expectation.
    task automatic run_scan(input string tag, input res_t e, input bit chk_vec, input int pulse_at);
        int n;
        exp_q.push_back(27'(e));
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check({tag, " busy_after_start"}, 32'(busy), 32'd1);
        check({tag, " done_cleared"},     32'(done), 32'd0);
        check({tag, " captured_cleared"}, 32'(captured), 32'd0);
        check({tag, " fv_cleared"},       32'(fail_valid), 32'd0);
        n = 0;
        while (!done && n < 100) begin
            if (chk_vec && n < 32) check({tag, " vector"}, 32'({a, b, c, d}), 32'(n / 2));
            if (n == pulse_at) start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            n++;
        end
        check({tag, " scan_cycles"}, 32'(n), 32'd32);
        check_results(tag);
    endtask

    typedef struct {
        string name;
        int    mode;
        res_t  exp;
    } vec_t;

    vec_t tbl[4];

    initial begin
        int n;
        // {captured, mismatch_cnt, first_fail, fail_valid, pass}
        tbl[0] = '{"golden", 0, '{16'hDF03, 5'd0, 4'd0, 1'b0, 1'b1}};
        tbl[1] = '{"stuck0", 1, '{16'h0000, 5'd9, 4'd0, 1'b1, 1'b0}};
        tbl[2] = '{"stuck1", 2, '{16'hFFFF, 5'd7, 4'd2, 1'b1, 1'b0}};
        tbl[3] = '{"fault13", 3, '{16'hFF03, 5'd1, 4'd13, 1'b1, 1'b0}};

        start = 1'b1;
        start0 = 1'b0;
        fault_mode = 0;

        // Reset held 2 cycles with start high: nothing may begin.
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst busy", 32'(busy), 32'd0);
        check("rst done", 32'(done), 32'd0);
        check("rst pass", 32'(pass), 32'd0);
        check("rst captured", 32'(captured), 32'd0);
        check("rst mismatch", 32'(mismatch_cnt), 32'd0);
        check("rst fail_valid", 32'(fail_valid), 32'd0);
        check("rst vec", 32'({a, b, c, d}), 32'd0);
        start = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;
        check("idle busy", 32'(busy), 32'd0);

        // Table-driven scans; each start from DONE also checks the restart clear.
        for (int i = 0; i < 4; i++) begin
            fault_mode = tbl[i].mode;
            run_scan(tbl[i].name, tbl[i].exp, (i == 0), -1);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            check({tbl[i].name, " done_held"}, 32'(done), 32'd1);
        end

        // start pulsed while vector 5 is applied: ignored, length unchanged.
        fault_mode = 0;
        run_scan("mid_start", tbl[0].exp, 1'b1, 11);

        // Reset while vector 7 is applied, then a clean rescan.
        fault_mode = 1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        while ({a, b, c, d} != 4'd7 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("reach_vec7", 32'({a, b, c, d}), 32'd7);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst busy", 32'(busy), 32'd0);
        check("midrst vec", 32'({a, b, c, d}), 32'd0);
        check("midrst mismatch", 32'(mismatch_cnt), 32'd0);
        check("midrst fail_valid", 32'(fail_valid), 32'd0);
        check("midrst captured", 32'(captured), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("midrst stays_idle", 32'(busy), 32'd0);
        fault_mode = 0;
        run_scan("rescan", tbl[0].exp, 1'b1, -1);

        // SETTLE=0 instance: 16-cycle scan of the golden block.
        start0 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0;
        n = 0;
        while (!done0 && n < 100) begin
            check("s0 vector", 32'({a0, b0, c0, d0}), 32'(n));
            @(posedge clk); #1;
            n++;
        end
        check("s0 scan_cycles", 32'(n), 32'd16);
        check("s0 captured", 32'(captured0), 32'hDF03);
        check("s0 pass", 32'(pass0), 32'd1);
        check("s0 mismatch", 32'(mismatch_cnt0), 32'd0);
        check("s0 fail_valid", 32'(fail_valid0), 32'd0);
        check("s0 busy", 32'(busy0), 32'd0);

        check("queue drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
